// File: rtl/aq_vfmau_wb_sched.sv
// aq_vfmau_wb_sched: issue/writeback scheduler for the EX1..EX5 vector FMA pipeline
module aq_vfmau_wb_sched #(
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 3,
  parameter int RESV_W = 5
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             issue_req,
  input  logic [LAT_W-1:0] issue_lat,
  output logic             issue_gnt,
  input  logic             pipe_stall,
  input  logic             pipe_flush,
  input  logic             ifu_vpu_warm_up,
  output logic             ex2_vld,
  output logic             ex3_vld,
  output logic             ex4_vld,
  output logic             ex5_vld,
  output logic             result_ready_in_ex3,
  output logic             result_ready_in_ex4,
  output logic             wb_vld,
  output logic [2:0]       wb_sel,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             idle,
  output logic             dp_clk_en
);
  logic [3:0]              r_vld;
  logic [2:0][LAT_W-1:0]   r_lat;
  logic [RESV_W-1:0]       r_resv;
  logic [CNT_W-1:0]        r_cnt;
  logic [LAT_W-1:0]        w_leff;
  logic                    w_run;
  logic                    w_fire;
  logic                    w_ret;
  logic [2:0]              w_ret_v;

  // lat 3 is reserved and runs as lat 2; reservation slot leff+2 is where the new op would land after the shift
  always_comb begin
    w_leff    = (issue_lat == LAT_W'(3)) ? LAT_W'(2) : issue_lat;
    w_run     = !pipe_stall & !pipe_flush;
    issue_gnt = cpurst_b & w_run & !r_resv[3'(w_leff) + 3'd2];
    w_fire    = issue_req & issue_gnt;
    w_ret     = r_resv[0] & w_run;
    w_ret_v   = {r_vld[3], r_vld[2] & (r_lat[2] == LAT_W'(1)), r_vld[1] & (r_lat[1] == LAT_W'(0))};
    wb_vld    = w_ret;
    wb_sel    = w_ret ? w_ret_v : 3'b000;
  end

  assign ex2_vld             = r_vld[0];
  assign ex3_vld             = r_vld[1];
  assign ex4_vld             = r_vld[2];
  assign ex5_vld             = r_vld[3];
  assign result_ready_in_ex3 = r_vld[0] & (r_lat[0] == LAT_W'(0));
  assign result_ready_in_ex4 = r_vld[1] & (r_lat[1] == LAT_W'(1));
  assign inflight_cnt        = r_cnt;
  assign idle                = (r_cnt == '0) & !issue_req;
  assign dp_clk_en           = !idle | ifu_vpu_warm_up;

  // advance stages and reservations; an op leaving its retire stage is dropped, flush clears everything
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_vld  <= '0;
      r_lat  <= '0;
      r_resv <= '0;
      r_cnt  <= '0;
    end else if (pipe_flush) begin
      r_vld  <= '0;
      r_resv <= '0;
      r_cnt  <= '0;
    end else if (!pipe_stall) begin
      r_vld[0] <= w_fire;
      r_lat[0] <= w_leff;
      r_vld[1] <= r_vld[0];
      r_lat[1] <= r_lat[0];
      r_vld[2] <= r_vld[1] & (r_lat[1] != LAT_W'(0));
      r_lat[2] <= r_lat[1];
      r_vld[3] <= r_vld[2] & (r_lat[2] == LAT_W'(2));
      r_resv   <= (r_resv >> 1) | (RESV_W'(w_fire) << (3'(w_leff) + 3'd1));
      r_cnt    <= r_cnt + CNT_W'(w_fire) - CNT_W'(w_ret);
    end
  end

  a_resv_matches_stage: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) r_resv[0] == |w_ret_v);
  a_single_retire: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) $onehot0(w_ret_v));
  a_cnt_matches_vld: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) r_cnt == CNT_W'($countones(r_vld)));
endmodule
